// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: result-source and FSM encodings,
// load funct3 constants and the pending-load record kept while waiting on memory.
package wb_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned DATA_W     = 32;

  // Result source; 2'b11 is reserved and behaves like WB_ALU.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WRITE     = 2'b01,
    S_WAIT_LOAD = 2'b10
  } state_e;

  // Instruction fields held while a load waits for its data.
  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [F3_W-1:0]       funct3;
    logic [1:0]            addr_lo;
  } load_req_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB instruction handshake.
// master: MEM stage (drives valid_i and instruction fields, receives ready_o)
// slave : WB stage  (receives instruction fields, drives ready_o)
interface wb_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic            reg_write_i;
  logic [4:0]      rd_addr_i;
  logic [1:0]      wb_sel_i;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] pc_plus4_i;
  logic [2:0]      funct3_i;
  logic [1:0]      addr_lo_i;

  modport master (
    output valid_i, reg_write_i, rd_addr_i, wb_sel_i, alu_result_i,
           pc_plus4_i, funct3_i, addr_lo_i,
    input  ready_o
  );

  modport slave (
    input  valid_i, reg_write_i, rd_addr_i, wb_sel_i, alu_result_i,
           pc_plus4_i, funct3_i, addr_lo_i,
    output ready_o
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load data alignment: selects the byte/halfword addressed by addr_lo from the
// raw memory word and sign- or zero-extends it according to funct3.
// Purely combinational.
//   funct3_i  load type
//   addr_lo_i byte offset within the word (bit 0 ignored for halfwords)
//   rdata_i   raw word from data memory
//   result_c  aligned, extended load value
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [F3_W-1:0]   funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (funct3_i)
      F3_LB:   result_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result_c = {24'h000000, byte_sel};
      F3_LH:   result_c = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result_c = {16'h0000, half_sel};
      F3_LW:   result_c = rdata_i;
      default: result_c = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RISC-V write-back stage. Accepts one instruction per cycle from MEM, waits for
// load data when needed, and issues a single-cycle register-file write plus a
// retire pulse per instruction. Counts retired instructions.
// Optional feature macro: WB_BYPASS_EN adds a forwarding port for the
// read-during-write case of the register file.
//   clk, rst         clock, synchronous active-high reset
//   mem              MEM->WB handshake (slave side)
//   dmem_rvalid_i    load data valid (only observed while waiting on a load)
//   dmem_rdata_i     raw load word
//   reg_write_en_o   register file write enable
//   rd_addr_o        register file write address
//   rd_data_o        register file write data
//   retire_o         one-cycle pulse per retired instruction
//   instret_o        retired-instruction count (wraps)
//   rs1/rs2_addr_i, fwd_rs1/rs2_hit_o, fwd_data_o  bypass (WB_BYPASS_EN only)
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_stage_if.slave             mem,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  reg_write_en_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  retire_o,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  fwd_rs1_hit_o,
  output logic                  fwd_rs2_hit_o,
  output logic [XLEN-1:0]       fwd_data_o,
`endif
  output logic [CNT_W-1:0]      instret_o
);

  state_e                state_q, state_d;
  load_req_t             pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  retire_q, retire_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic [CNT_W-1:0]      instret_q, instret_d;

  logic                  accept;
  logic [DATA_W-1:0]     load_data;

  wb_stage_load_align u_load_align (
    .funct3_i  (pend_q.funct3),
    .addr_lo_i (pend_q.addr_lo),
    .rdata_i   (dmem_rdata_i),
    .result_c  (load_data)
  );

  assign accept = mem.valid_i && ready_q;

  // Next state and next register-write contents; outputs are the registered
  // image of entering S_WRITE, so they appear in the cycle the FSM sits in WRITE.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    we_d      = 1'b0;
    retire_d  = 1'b0;
    instret_d = instret_q;
    ready_d   = 1'b1;

    unique case (state_q)
      S_IDLE, S_WRITE: begin
        if (accept) begin
          if (mem.wb_sel_i == WB_LOAD) begin
            pend_d.reg_write = mem.reg_write_i;
            pend_d.rd_addr   = mem.rd_addr_i;
            pend_d.funct3    = mem.funct3_i;
            pend_d.addr_lo   = mem.addr_lo_i;
            state_d          = S_WAIT_LOAD;
          end else begin
            rd_addr_d = mem.rd_addr_i;
            rd_data_d = (mem.wb_sel_i == WB_PC4) ? mem.pc_plus4_i : mem.alu_result_i;
            we_d      = mem.reg_write_i && (mem.rd_addr_i != '0);
            state_d   = S_WRITE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_LOAD: begin
        if (dmem_rvalid_i) begin
          rd_addr_d = pend_q.rd_addr;
          rd_data_d = XLEN'(load_data);
          we_d      = pend_q.reg_write && (pend_q.rd_addr != '0);
          state_d   = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every entry into WRITE retires exactly one instruction.
    if (state_d == S_WRITE) begin
      retire_d  = 1'b1;
      instret_d = instret_q + CNT_W'(1);
    end
    ready_d = (state_d != S_WAIT_LOAD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      retire_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      retire_q  <= retire_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      instret_q <= instret_d;
    end
  end

  assign mem.ready_o    = ready_q;
  assign reg_write_en_o = we_q;
  assign rd_addr_o      = rd_addr_q;
  assign rd_data_o      = rd_data_q;
  assign retire_o       = retire_q;
  assign instret_o      = instret_q;

`ifdef WB_BYPASS_EN
  // Register file returns the old value during its write cycle; forward instead.
  assign fwd_rs1_hit_o = we_q && (rd_addr_q == rs1_addr_i);
  assign fwd_rs2_hit_o = we_q && (rd_addr_q == rs2_addr_i);
  assign fwd_data_o    = rd_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        we;
  logic [4:0]  rd_o;
  logic [31:0] data_o;
  logic        retire;
  logic [63:0] instret;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1, rs2;
  logic        hit1, hit2;
  logic [31:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  wb_stage_if #(.XLEN(32)) mem_if ();

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem            (mem_if.slave),
    .dmem_rvalid_i  (dmem_rvalid),
    .dmem_rdata_i   (dmem_rdata),
    .reg_write_en_o (we),
    .rd_addr_o      (rd_o),
    .rd_data_o      (data_o),
    .retire_o       (retire),
`ifdef WB_BYPASS_EN
    .rs1_addr_i     (rs1),
    .rs2_addr_i     (rs2),
    .fwd_rs1_hit_o  (hit1),
    .fwd_rs2_hit_o  (hit2),
    .fwd_data_o     (fwd_data),
`endif
    .instret_o      (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference load alignment from the ISA rules, using shifts and masks.
  function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (32'(lo) * 8)) & 32'h0000_00FF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (32'(lo[1]) * 16)) & 32'h0000_FFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Transaction-level model: at most one load outstanding; a write happens in
  // the cycle after a non-load accept or after the load's data arrives.
  logic        m_live = 1'b0;
  logic        m_busy;
  logic        p_rw;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  logic [1:0]  p_lo;
  logic        m_we, m_ret;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_live <= 1'b1;
      m_busy <= 1'b0;
      m_we   <= 1'b0;
      m_ret  <= 1'b0;
      m_rd   <= 5'd0;
      m_data <= 32'd0;
      m_cnt  <= 64'd0;
    end else if (m_live) begin
      if (m_busy) begin
        m_ret <= dmem_rvalid;
        m_we  <= dmem_rvalid && p_rw && (p_rd != 5'd0);
        if (dmem_rvalid) begin
          m_busy <= 1'b0;
          m_rd   <= p_rd;
          m_data <= ref_align(p_f3, p_lo, dmem_rdata);
          m_cnt  <= m_cnt + 64'd1;
        end
      end else if (mem_if.valid_i) begin
        if (mem_if.wb_sel_i == 2'b01) begin
          m_busy <= 1'b1;
          p_rw   <= mem_if.reg_write_i;
          p_rd   <= mem_if.rd_addr_i;
          p_f3   <= mem_if.funct3_i;
          p_lo   <= mem_if.addr_lo_i;
          m_we   <= 1'b0;
          m_ret  <= 1'b0;
        end else begin
          m_ret  <= 1'b1;
          m_we   <= mem_if.reg_write_i && (mem_if.rd_addr_i != 5'd0);
          m_rd   <= mem_if.rd_addr_i;
          m_data <= (mem_if.wb_sel_i == 2'b10) ? mem_if.pc_plus4_i : mem_if.alu_result_i;
          m_cnt  <= m_cnt + 64'd1;
        end
      end else begin
        m_we  <= 1'b0;
        m_ret <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_ready",   64'(mem_if.ready_o), 64'(!m_busy));
      chk("cmp_we",      64'(we), 64'(m_we));
      chk("cmp_retire",  64'(retire), 64'(m_ret));
      chk("cmp_rd",      64'(rd_o), 64'(m_rd));
      chk("cmp_data",    64'(data_o), 64'(m_data));
      chk("cmp_instret", instret, m_cnt);
`ifdef WB_BYPASS_EN
      chk("cmp_hit1", 64'(hit1), 64'(m_we && (m_rd == rs1)));
      chk("cmp_hit2", 64'(hit2), 64'(m_we && (m_rd == rs2)));
      chk("cmp_fwd",  64'(fwd_data), 64'(m_data));
`endif
    end
  end

  task automatic idle_inputs();
    mem_if.valid_i      = 1'b0;
    mem_if.reg_write_i  = 1'b0;
    mem_if.rd_addr_i    = 5'd0;
    mem_if.wb_sel_i     = 2'b00;
    mem_if.alu_result_i = 32'd0;
    mem_if.pc_plus4_i   = 32'd0;
    mem_if.funct3_i     = 3'd0;
    mem_if.addr_lo_i    = 2'd0;
  endtask

  task automatic set_op(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [2:0] f3, input logic [1:0] lo);
    mem_if.valid_i      = 1'b1;
    mem_if.wb_sel_i     = sel;
    mem_if.reg_write_i  = rw;
    mem_if.rd_addr_i    = rd;
    mem_if.alu_result_i = alu;
    mem_if.pc_plus4_i   = pc4;
    mem_if.funct3_i     = f3;
    mem_if.addr_lo_i    = lo;
  endtask

  // Called just after a negedge; leaves the DUT freshly reset, inputs idle.
  task automatic do_reset();
    idle_inputs();
    dmem_rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue a load, return data after waitn empty cycles plus the rvalid cycle.
  task automatic load_op(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word,
                         input logic [4:0] rd, input int waitn,
                         output logic [31:0] got, output logic got_we);
    set_op(2'b01, 1'b1, rd, $urandom, $urandom, f3, lo);
    @(negedge clk);
    chk("load_ready_low", 64'(mem_if.ready_o), 64'd0);
    #1 idle_inputs();
    for (int i = 0; i < waitn; i++) begin
      @(negedge clk);
      chk("load_wait_ready", 64'(mem_if.ready_o), 64'd0);
      chk("load_wait_we", 64'(we), 64'd0);
      #1;
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = word;
    @(negedge clk);
    got    = data_o;
    got_we = we;
    chk("load_ready_back", 64'(mem_if.ready_o), 64'd1);
    #1 dmem_rvalid = 1'b0;
  endtask

  logic [31:0] got;
  logic        got_we;

  initial begin
    rst = 1'b1;
    idle_inputs();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
`ifdef WB_BYPASS_EN
    rs1 = 5'd0;
    rs2 = 5'd0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_we",      64'(we), 64'd0);
    chk("rst_retire",  64'(retire), 64'd0);
    chk("rst_rd",      64'(rd_o), 64'd0);
    chk("rst_data",    64'(data_o), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ready",   64'(mem_if.ready_o), 64'd1);

    // Single ALU op.
    #1 rst = 1'b0;
    set_op(2'b00, 1'b1, 5'd5, 32'h0000_1234, 32'hAAAA_0004, 3'd0, 2'd0);
    @(negedge clk);
    chk("alu_we",      64'(we), 64'd1);
    chk("alu_rd",      64'(rd_o), 64'd5);
    chk("alu_data",    64'(data_o), 64'h1234);
    chk("alu_retire",  64'(retire), 64'd1);
    chk("alu_instret", instret, 64'd1);
    #1 idle_inputs();

    // Four back-to-back ALU ops.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_op(2'b00, 1'b1, 5'(10 + k), 32'h100 + 32'(k), 32'h0, 3'd0, 2'd0);
      @(negedge clk);
      chk("b2b_ready", 64'(mem_if.ready_o), 64'd1);
      chk("b2b_we",    64'(we), 64'd1);
      chk("b2b_rd",    64'(rd_o), 64'(10 + k));
      chk("b2b_data",  64'(data_o), 64'h100 + 64'(k));
      #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("b2b_instret", instret, 64'd4);
    chk("b2b_idle_we", 64'(we), 64'd0);
    #1;

    // PC+4 source and reserved select treated as ALU.
    set_op(2'b10, 1'b1, 5'd1, 32'h1111_1111, 32'h0000_2004, 3'd0, 2'd0);
    @(negedge clk);
    chk("pc4_data", 64'(data_o), 64'h2004);
    #1 set_op(2'b11, 1'b1, 5'd2, 32'h3333_3333, 32'h4444_4444, 3'd0, 2'd0);
    @(negedge clk);
    chk("rsv_data", 64'(data_o), 64'h3333_3333);
    #1 idle_inputs();

    // Loads.
    load_op(3'b000, 2'd3, 32'h80FF_0000, 5'd9, 4, got, got_we);
    chk("lb_data", 64'(got), 64'hFFFF_FF80);
    chk("lb_we",   64'(got_we), 64'd1);
    load_op(3'b101, 2'd2, 32'hBEEF_0001, 5'd7, 0, got, got_we);
    chk("lhu_data", 64'(got), 64'h0000_BEEF);
    load_op(3'b001, 2'd2, 32'hBEEF_0001, 5'd7, 1, got, got_we);
    chk("lh_data", 64'(got), 64'hFFFF_BEEF);
    load_op(3'b100, 2'd1, 32'h1234_F678, 5'd3, 2, got, got_we);
    chk("lbu_data", 64'(got), 64'h0000_00F6);
    load_op(3'b010, 2'd3, 32'hCAFE_F00D, 5'd4, 0, got, got_we);
    chk("lw_data", 64'(got), 64'hCAFE_F00D);

    // Write to x0 still retires; stray rvalid while idle does nothing.
    set_op(2'b00, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0);
    @(negedge clk);
    chk("x0_we",     64'(we), 64'd0);
    chk("x0_retire", 64'(retire), 64'd1);
    #1 idle_inputs();
    @(negedge clk);
    #1 dmem_rvalid = 1'b1;
    dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("stray_we",     64'(we), 64'd0);
    chk("stray_retire", 64'(retire), 64'd0);
    #1 dmem_rvalid = 1'b0;

    // Reset while waiting on a load; the late rvalid must be ignored.
    set_op(2'b01, 1'b1, 5'd6, 32'h0, 32'h0, 3'b010, 2'd0);
    @(negedge clk);
    #1 idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    @(negedge clk);
    chk("midrst_we",      64'(we), 64'd0);
    chk("midrst_retire",  64'(retire), 64'd0);
    chk("midrst_instret", instret, 64'd0);
    chk("midrst_ready",   64'(mem_if.ready_o), 64'd1);
    #1 dmem_rvalid = 1'b0;

    // Randomized traffic, checked by the per-cycle compare against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      mem_if.valid_i      = ($urandom_range(0, 9) < 7);
      mem_if.wb_sel_i     = 2'($urandom_range(0, 3));
      mem_if.reg_write_i  = 1'($urandom);
      mem_if.rd_addr_i    = 5'($urandom);
      mem_if.alu_result_i = $urandom;
      mem_if.pc_plus4_i   = $urandom;
      mem_if.funct3_i     = 3'($urandom);
      mem_if.addr_lo_i    = 2'($urandom);
      dmem_rvalid         = ($urandom_range(0, 2) == 0);
      dmem_rdata          = $urandom;
`ifdef WB_BYPASS_EN
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
`endif
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    idle_inputs();
    dmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
